u409_cycle_terminator: RTL and testbench
========================================

# u409_cycle_terminator

Parametrised MC68040/MC68060 cycle-termination engine for U409. It arbitrates NUM_CH local responders (ROM, autovector, RTC, CIA and future slots), times each cycle by a per-channel fixed delay or a synchronised ready handshake, and drives TACKn/TBIn/TCIn/TEAn with a clean assert, drive-high, release sequence. A built-in watchdog terminates unclaimed cycles with either TACKn or TEAn.

## Interface
- NUM_CH, 4: number of responder channels, 1..8.
- CNT_W, 8: width of the delay and watchdog counters.
- TACK_LEN, 2: CLK80 clocks the strobe is held low, at least 1.
- TIMEOUT, 249: watchdog clocks from cycle start to forced termination, below 2^CNT_W.
- TEA_ON_TIMEOUT, 0: 1 means the watchdog terminates with TEAn instead of TACKn.
- CLK80  in  1  system clock; all state on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- CLK40  in  1  CPU bus clock phase; a cycle starts only when CLK40=1.
- TSn  in  1  CPU transfer start, active low.
- ABORT  in  1  cycle owned by another agent (Agnus space); returns the engine to IDLE.
- CH_REQ  in  NUM_CH  address decode per channel, qualified at TS.
- CH_MODE  in  NUM_CH  0 = fixed delay, 1 = ready handshake.
- CH_DELAY  in  NUM_CH*CNT_W  per-channel delay, channel i at bits [i*CNT_W +: CNT_W].
- CH_READY  in  NUM_CH  asynchronous ready (CIA-style), used when CH_MODE=1.
- CH_NOCACHE  in  NUM_CH  terminate this channel with TCIn as well.
- TACKn  inout  1  transfer acknowledge, tri-state.
- TBIn  out  1  burst inhibit, tri-state.
- TCIn  out  1  cache inhibit, tri-state.
- TEAn  out  1  transfer error, tri-state.
- CH_SEL_n  out  NUM_CH  active-low per-channel select, held for the whole cycle.
- BUSY  out  1  engine not in IDLE.

## Operation
- States: IDLE, WAIT, STROBE, NEGATE, HOLD.
- **IDLE.** A cycle starts on a CLK80 edge with CLK40=1, TSn=0 and ABORT=0.
  - The winner is the lowest-index channel with CH_REQ set.
  - The engine latches the winner's index, mode, delay and nocache bit, asserts its CH_SEL_n, and goes to WAIT.
  - If no channel requests, the watchdog channel is selected: no CH_SEL_n is asserted and the delay is TIMEOUT.
- **WAIT, fixed mode.** The counter runs from 1. On reaching the delay value, go to STROBE. A delay of 0 is treated as 1.
- **WAIT, ready mode.** CH_READY goes through a 2-flop synchroniser. Go to STROBE when the synchronised value is 1 for 2 consecutive clocks and CLK40=0.
  - The watchdog count still runs in ready mode. Hitting TIMEOUT forces a watchdog termination.
- **Watchdog termination.** If the selected channel is the watchdog and TACKn is sampled low (another responder answered), return to IDLE without driving.
- **STROBE.** Drive low for TACK_LEN clocks:
  - normal termination: TACKn and TBIn, plus TCIn if the nocache bit is set;
  - watchdog termination with TEA_ON_TIMEOUT=1: TEAn and TBIn instead.
- **NEGATE.** Drive the same outputs high for 1 clock, then go to HOLD.
- **HOLD.** Release all drivers. CH_SEL_n stays low for 3 more clocks, as ROM hold time, then deasserts. Go to IDLE.
- **ABORT.** Asserted in WAIT, it returns the engine to IDLE next clock with drivers released. ABORT is ignored during STROBE and NEGATE so that no strobe is truncated.
- A TSn pulse seen while BUSY is ignored.
- **Reset** (RESETn low, at any point including mid-strobe):
  - all tri-state outputs released (z);
  - CH_SEL_n all 1s, BUSY=0, state IDLE;
  - counters and synchronisers cleared.

## Timing
- Start edge is E0. In fixed mode with delay D, TACKn first samples low at E0+D+1.
- TACKn is low for exactly TACK_LEN clocks, driven high for 1 clock, then z.
- CH_SEL_n falls at E0 and rises 3 clocks after release.
- Ready mode: CH_READY rising to strobe takes 3 to 4 clocks, plus any wait for CLK40=0.
- Back-to-back: the earliest next start is the first CLK40=1 edge after HOLD ends.

## Structure
- Shared package u409_pkg holds:
  - state encoding constants;
  - the CH_SEL_n hold length (3);
  - the default TIMEOUT (249).
- One sub-module, u409_sync2: a 2-flop synchroniser, instantiated per CH_READY bit.
- The priority encoder and counter stay inline.

## Test plan
- **Fixed delay.** Channel 0, delay 5, TSn low with CLK40=1 at E0 → TACKn/TBIn low at E0+6 and E0+7, high at E0+8, z at E0+9; CH_SEL_n[0] high at E0+12.
- **Priority and nocache.** CH_REQ=4'b0110, CH_NOCACHE[1]=1, delay 3 → only CH_SEL_n[1] asserted, and TCIn is strobed together with TACKn.
- **Ready mode.** Channel 2, ready mode; CH_READY rises 40 clocks after start → strobe follows within 3 to 4 clocks at a CLK40=0 edge.
- **Watchdog.** No CH_REQ, TEA_ON_TIMEOUT=1 → TEAn/TBIn low at E0+250, and TACKn stays z. Repeat with external TACKn low at E0+100 → engine returns to IDLE and drives nothing.
- **Abort and TS while busy.** ABORT in WAIT → drivers stay z and BUSY=0 next clock. A TSn pulse while BUSY → no second cycle.
- **Mid-strobe reset.** RESETn low during STROBE → all outputs z immediately, CH_SEL_n=1s; after RESETn rises, a new cycle runs normally.

Source files
------------

// File: rtl/u409_pkg.sv
// Shared definitions for the U409 cycle-termination engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package u409_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STROBE = 3'd2,
        ST_NEGATE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Clocks CH_SEL_n stays low after the drivers release (ROM hold time).
    localparam int SEL_HOLD_LEN    = 3;
    localparam int DEFAULT_TIMEOUT = 249;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/u409_sync2.sv
// Two-flop synchroniser for one asynchronous ready line.
// Latency: 2 CLK80 clocks.
// Backpressure: none.
module u409_sync2 (
    input  logic CLK80,
    input  logic RESETn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK80 or negedge RESETn) begin
        if (!RESETn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/u409_cycle_terminator.sv
// 68040/060 cycle terminator: priority-selects a responder, times it, strobes TACKn/TBIn/TCIn/TEAn.
// Latency: fixed mode D+1 clocks from TS edge to strobe; ready mode 3-4 clocks after ready.
// Backpressure: TSn ignored while BUSY; ABORT honoured only in WAIT.
module u409_cycle_terminator
    import u409_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 8,
    parameter int TACK_LEN       = 2,
    parameter int TIMEOUT        = DEFAULT_TIMEOUT,
    parameter int TEA_ON_TIMEOUT = 0
) (
    input  logic                    CLK80,
    input  logic                    RESETn,
    input  logic                    CLK40,
    input  logic                    TSn,
    input  logic                    ABORT,
    input  logic [NUM_CH-1:0]       CH_REQ,
    input  logic [NUM_CH-1:0]       CH_MODE,
    input  logic [NUM_CH*CNT_W-1:0] CH_DELAY,
    input  logic [NUM_CH-1:0]       CH_READY,
    input  logic [NUM_CH-1:0]       CH_NOCACHE,
    inout  tri logic                TACKn,
    output tri logic                TBIn,
    output tri logic                TCIn,
    output tri logic                TEAn,
    output logic [NUM_CH-1:0]       CH_SEL_n,
    output logic                    BUSY
);

    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SUB_MAX = max_int(TACK_LEN, SEL_HOLD_LEN);
    localparam int SUB_W   = $clog2(SUB_MAX + 1);
    localparam bit USE_TEA = (TEA_ON_TIMEOUT != 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic               wd_term_q, wd_term_d;
    logic [IDX_W-1:0]   idx_q;
    logic               mode_q;
    logic               nc_q;
    logic               wd_sel_q;
    logic [CNT_W-1:0]   delay_q;
    logic [NUM_CH-1:0]  sel_q;
    logic               rdy_d_q;

    logic               start;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_CH-1:0]  win_onehot;
    logic [CNT_W-1:0]   ch_delay;
    logic [CNT_W-1:0]   delay_start;
    logic [NUM_CH-1:0]  rdy_sync;
    logic               rdy_sel;
    logic               rdy_ok;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        u409_sync2 u_sync (
            .CLK80  (CLK80),
            .RESETn (RESETn),
            .d      (CH_READY[g]),
            .q      (rdy_sync[g])
        );
    end

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        win_vld    = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (CH_REQ[i]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
        if (win_vld) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

    always_comb begin
        ch_delay = CH_DELAY[int'(win_idx)*CNT_W +: CNT_W];
        if (!win_vld) begin
            delay_start = CNT_W'(TIMEOUT);
        end else if (ch_delay == '0) begin
            delay_start = CNT_W'(1);
        end else begin
            delay_start = ch_delay;
        end
    end

    assign rdy_sel = rdy_sync[idx_q];
    assign rdy_ok  = rdy_sel && rdy_d_q && !CLK40;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        wd_term_d = wd_term_q;
        start     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CLK40 && !TSn && !ABORT) begin
                    start     = 1'b1;
                    state_d   = ST_WAIT;
                    cnt_d     = CNT_W'(1);
                    wd_term_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (wd_sel_q && (TACKn == 1'b0)) begin
                    // Some other responder claimed the unclaimed cycle.
                    state_d = ST_IDLE;
                end else if (!mode_q) begin
                    if (cnt_q >= delay_q) begin
                        state_d   = ST_STROBE;
                        sub_d     = SUB_W'(1);
                        wd_term_d = wd_sel_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    if (cnt_q >= CNT_W'(TIMEOUT)) begin
                        state_d   = ST_STROBE;
                        sub_d     = SUB_W'(1);
                        wd_term_d = 1'b1;
                    end else if (rdy_ok) begin
                        state_d   = ST_STROBE;
                        sub_d     = SUB_W'(1);
                        wd_term_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_STROBE: begin
                if (sub_q >= SUB_W'(TACK_LEN)) begin
                    state_d = ST_NEGATE;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
            ST_NEGATE: begin
                state_d = ST_HOLD;
                sub_d   = SUB_W'(1);
            end
            ST_HOLD: begin
                if (sub_q >= SUB_W'(SEL_HOLD_LEN)) begin
                    state_d = ST_IDLE;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK80 or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sub_q     <= '0;
            wd_term_q <= 1'b0;
            idx_q     <= '0;
            mode_q    <= 1'b0;
            nc_q      <= 1'b0;
            wd_sel_q  <= 1'b0;
            delay_q   <= '0;
            sel_q     <= '0;
            rdy_d_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            wd_term_q <= wd_term_d;
            rdy_d_q   <= (state_q == ST_WAIT) ? rdy_sel : 1'b0;
            if (start) begin
                idx_q    <= win_idx;
                mode_q   <= win_vld & CH_MODE[win_idx];
                nc_q     <= win_vld & CH_NOCACHE[win_idx];
                wd_sel_q <= !win_vld;
                delay_q  <= delay_start;
                sel_q    <= win_onehot;
            end else if (state_d == ST_IDLE) begin
                sel_q <= '0;
            end
        end
    end

    // Drivers: low through STROBE, actively high for NEGATE, released otherwise.
    logic drv_act;
    logic drv_lvl;
    logic use_tea;

    assign drv_act = (state_q == ST_STROBE) || (state_q == ST_NEGATE);
    assign drv_lvl = (state_q == ST_NEGATE);
    assign use_tea = USE_TEA && wd_term_q;

    assign TACKn = (drv_act && !use_tea)              ? drv_lvl : 1'bz;
    assign TBIn  = drv_act                            ? drv_lvl : 1'bz;
    assign TCIn  = (drv_act && nc_q && !wd_term_q)    ? drv_lvl : 1'bz;
    assign TEAn  = (drv_act && use_tea)               ? drv_lvl : 1'bz;

    assign CH_SEL_n = ~sel_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_u409_cycle_terminator.sv
// Directed bench for u409_cycle_terminator (watchdog configured to terminate with TEAn).
module tb_u409_cycle_terminator;

    localparam logic [1:0] LO = 2'd0;
    localparam logic [1:0] HI = 2'd1;
    localparam logic [1:0] RZ = 2'd2;

    logic        CLK80 = 1'b0;
    logic        CLK40 = 1'b0;
    logic        RESETn;
    logic        TSn;
    logic        ABORT;
    logic [3:0]  CH_REQ;
    logic [3:0]  CH_MODE;
    logic [31:0] CH_DELAY;
    logic [3:0]  CH_READY;
    logic [3:0]  CH_NOCACHE;
    logic        tack_ext;
    wire         TACKn;
    wire         TBIn;
    wire         TCIn;
    wire         TEAn;
    wire  [3:0]  CH_SEL_n;
    wire         BUSY;

    int tests = 0;
    int fails = 0;
    int k;

    pullup (TACKn);
    assign TACKn = tack_ext ? 1'b0 : 1'bz;

    wire [1:0] tbi_s = (TBIn === 1'bz) ? RZ : {1'b0, TBIn};
    wire [1:0] tci_s = (TCIn === 1'bz) ? RZ : {1'b0, TCIn};
    wire [1:0] tea_s = (TEAn === 1'bz) ? RZ : {1'b0, TEAn};

    u409_cycle_terminator #(
        .NUM_CH         (4),
        .CNT_W          (8),
        .TACK_LEN       (2),
        .TIMEOUT        (249),
        .TEA_ON_TIMEOUT (1)
    ) dut (
        .CLK80      (CLK80),
        .RESETn     (RESETn),
        .CLK40      (CLK40),
        .TSn        (TSn),
        .ABORT      (ABORT),
        .CH_REQ     (CH_REQ),
        .CH_MODE    (CH_MODE),
        .CH_DELAY   (CH_DELAY),
        .CH_READY   (CH_READY),
        .CH_NOCACHE (CH_NOCACHE),
        .TACKn      (TACKn),
        .TBIn       (TBIn),
        .TCIn       (TCIn),
        .TEAn       (TEAn),
        .CH_SEL_n   (CH_SEL_n),
        .BUSY       (BUSY)
    );

    always #5 CLK80 = ~CLK80;
    always @(negedge CLK80) CLK40 <= ~CLK40;

    task automatic tick;
        @(posedge CLK80);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves time just after E0, an edge with CLK40=1 and TSn=0.
    task automatic start_cycle;
        tick();
        if (CLK40 !== 1'b0) tick();
        TSn = 1'b0;
        tick();
        TSn = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 20 && BUSY !== 1'b0; n++) tick();
        chk(tag, BUSY, 1'b0);
    endtask

    initial begin
        RESETn = 1'b0; TSn = 1'b1; ABORT = 1'b0; CH_REQ = '0; CH_MODE = '0;
        CH_DELAY = '0; CH_READY = '0; CH_NOCACHE = '0; tack_ext = 1'b0;

        // Reset state
        tickn(3);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_sel", CH_SEL_n, 4'hF);
        chk("rst_tbi", tbi_s, RZ);
        chk("rst_tci", tci_s, RZ);
        chk("rst_tea", tea_s, RZ);
        chk("rst_tack", TACKn, 1'b1);
        RESETn = 1'b1;
        tickn(2);

        // Fixed delay 5 on channel 0
        CH_REQ = 4'b0001; CH_DELAY[7:0] = 8'd5;
        start_cycle();
        CH_REQ = '0;
        chk("fx_busy", BUSY, 1'b1);
        chk("fx_sel", CH_SEL_n, 4'b1110);
        tickn(4);
        chk("fx_e4_tbi", tbi_s, RZ);
        tick();
        chk("fx_e5_tack", TACKn, 1'b0);
        chk("fx_e5_tbi", tbi_s, LO);
        chk("fx_e5_tci", tci_s, RZ);
        tick();
        chk("fx_e6_tbi", tbi_s, LO);
        tick();
        chk("fx_e7_tack", TACKn, 1'b1);
        chk("fx_e7_tbi", tbi_s, HI);
        tick();
        chk("fx_e8_tbi", tbi_s, RZ);
        chk("fx_e8_sel", CH_SEL_n, 4'b1110);
        tickn(2);
        chk("fx_e10_sel", CH_SEL_n, 4'b1110);
        tick();
        chk("fx_e11_sel", CH_SEL_n, 4'b1111);
        chk("fx_e11_busy", BUSY, 1'b0);

        // Priority and nocache
        CH_REQ = 4'b0110; CH_NOCACHE = 4'b0010; CH_DELAY = 32'h0007_0300;
        start_cycle();
        CH_REQ = '0;
        chk("pri_sel", CH_SEL_n, 4'b1101);
        tickn(2);
        chk("pri_e2_tci", tci_s, RZ);
        tick();
        chk("pri_e3_tack", TACKn, 1'b0);
        chk("pri_e3_tci", tci_s, LO);
        chk("pri_e3_tbi", tbi_s, LO);
        tick();
        chk("pri_e4_tci", tci_s, LO);
        tick();
        chk("pri_e5_tci", tci_s, HI);
        tick();
        chk("pri_e6_tci", tci_s, RZ);
        tickn(3);
        chk("pri_e9_busy", BUSY, 1'b0);
        CH_NOCACHE = '0;

        // Ready handshake on channel 2
        CH_REQ = 4'b0100; CH_MODE = 4'b0100;
        start_cycle();
        CH_REQ = '0;
        chk("rdy_sel", CH_SEL_n, 4'b1011);
        tickn(39);
        chk("rdy_e39_tbi", tbi_s, RZ);
        chk("rdy_e39_busy", BUSY, 1'b1);
        CH_READY[2] = 1'b1;
        k = 0;
        while (tbi_s != LO && k < 8) begin
            tick();
            k++;
        end
        chk("rdy_latency", k, 4);
        chk("rdy_clk40", CLK40, 1'b0);
        chk("rdy_tack", TACKn, 1'b0);
        wait_idle("rdy_idle");
        CH_READY = '0; CH_MODE = '0;

        // Watchdog, nobody answers
        start_cycle();
        chk("wd_sel", CH_SEL_n, 4'b1111);
        chk("wd_busy", BUSY, 1'b1);
        tickn(248);
        chk("wd_e248_tea", tea_s, RZ);
        tick();
        chk("wd_e249_tea", tea_s, LO);
        chk("wd_e249_tbi", tbi_s, LO);
        chk("wd_e249_tack", TACKn, 1'b1);
        chk("wd_e249_tci", tci_s, RZ);
        tick();
        chk("wd_e250_tea", tea_s, LO);
        tick();
        chk("wd_e251_tea", tea_s, HI);
        tick();
        chk("wd_e252_tea", tea_s, RZ);
        tickn(3);
        chk("wd_e255_busy", BUSY, 1'b0);

        // Watchdog, external TACKn at E0+100
        start_cycle();
        tickn(99);
        tack_ext = 1'b1;
        tick();
        chk("wdx_busy", BUSY, 1'b0);
        chk("wdx_tea", tea_s, RZ);
        chk("wdx_tbi", tbi_s, RZ);
        tack_ext = 1'b0;
        tickn(160);
        chk("wdx_late_tea", tea_s, RZ);
        chk("wdx_late_busy", BUSY, 1'b0);

        // Abort in WAIT
        CH_REQ = 4'b0001; CH_DELAY = 32'd20;
        start_cycle();
        CH_REQ = '0;
        tickn(3);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("ab_busy", BUSY, 1'b0);
        chk("ab_sel", CH_SEL_n, 4'b1111);
        chk("ab_tbi", tbi_s, RZ);
        tickn(25);
        chk("ab_late_tbi", tbi_s, RZ);
        chk("ab_late_busy", BUSY, 1'b0);

        // TSn pulse while busy
        CH_REQ = 4'b0001; CH_DELAY = 32'd10;
        start_cycle();
        tickn(2);
        TSn = 1'b0;
        tickn(2);
        TSn = 1'b1;
        tickn(6);
        chk("tsb_e10_tbi", tbi_s, LO);
        tickn(6);
        chk("tsb_e16_busy", BUSY, 1'b0);
        CH_REQ = '0;
        tickn(4);
        chk("tsb_late_busy", BUSY, 1'b0);

        // Reset during STROBE, then a clean cycle
        CH_REQ = 4'b0001; CH_DELAY = 32'd2;
        start_cycle();
        tickn(2);
        chk("mr_strobe_tbi", tbi_s, LO);
        #2 RESETn = 1'b0;
        #1;
        chk("mr_tbi", tbi_s, RZ);
        chk("mr_tack", TACKn, 1'b1);
        chk("mr_sel", CH_SEL_n, 4'b1111);
        chk("mr_busy", BUSY, 1'b0);
        tick();
        RESETn = 1'b1;
        tick();
        start_cycle();
        CH_REQ = '0;
        chk("mr2_sel", CH_SEL_n, 4'b1110);
        tickn(2);
        chk("mr2_tack", TACKn, 1'b0);
        chk("mr2_tbi", tbi_s, LO);
        tickn(2);
        chk("mr2_neg_tbi", tbi_s, HI);
        tick();
        chk("mr2_rel_tbi", tbi_s, RZ);
        wait_idle("mr2_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
